// File: rtl/fft_pingpong_ram.sv
// Ping-pong sample memory for the FFT datapath.
// Two banks of 2^ADDR_W words share one true dual-port array. The bank
// address bit is bank_sel ^ x_alt. Butterflies work in the active bank while
// the other bank is loaded or unloaded. A swap handshake exchanges the roles
// of the two banks, and it only toggles in a cycle where both ports are idle.
//
// Swap FSM states:
//   state | meaning
//   IDLE  | no swap outstanding; a request with both ports idle swaps at once
//   PEND  | request seen while a port was busy; swap at the first idle cycle
module fft_pingpong_ram #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 5,
   parameter int RDW_MODE = 0,
   parameter int OUT_REG  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_en,
   input  logic              a_wr,
   input  logic              a_alt,
   input  logic              a_bitrev,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic [DATA_W-1:0] a_q,
   output logic              a_valid,
   input  logic              b_en,
   input  logic              b_wr,
   input  logic              b_alt,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic [DATA_W-1:0] b_q,
   output logic              b_valid,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              bank_sel,
   output logic              collision
);

   localparam int DEPTH = 2 ** (ADDR_W + 1);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } swap_state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] a_eff;
   logic [ADDR_W:0]   a_pa;
   logic [ADDR_W:0]   b_pa;
   logic              a_rd;
   logic              b_rd;
   logic              a_we;
   logic              b_we_req;
   logic              b_we;
   logic              addr_hit;
   logic              coll;
   logic              ports_idle;
   logic [DATA_W-1:0] a_rd_next;
   logic [DATA_W-1:0] b_rd_next;

   logic [DATA_W-1:0] a_q1;
   logic [DATA_W-1:0] b_q1;
   logic              a_v1;
   logic              b_v1;
   logic              col1;

   swap_state_t       state;

   // Port A effective address, optionally bit-reversed.
   always_comb begin
      a_eff = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         a_eff[i] = a_bitrev ? a_addr[ADDR_W-1-i] : a_addr[i];
      end
   end

   // Physical addresses, access decode and cross-port conflict detection.
   always_comb begin
      a_pa       = {bank_sel ^ a_alt, a_eff};
      b_pa       = {bank_sel ^ b_alt, b_addr};
      a_rd       = a_en & ~a_wr;
      b_rd       = b_en & ~b_wr;
      a_we       = a_en & a_wr & ~rst;
      b_we_req   = b_en & b_wr & ~rst;
      addr_hit   = (a_pa == b_pa);
      coll       = a_en & b_en & addr_hit & (a_wr | b_wr);
      // Write/write to the same word: port A wins, port B is dropped.
      b_we       = b_we_req & ~(a_we & addr_hit);
      ports_idle = ~a_en & ~b_en;
   end

   // Read data, with the other port's write data forwarded in write-first mode.
   always_comb begin
      a_rd_next = mem[a_pa];
      b_rd_next = mem[b_pa];
      if (RDW_MODE == 1) begin
         if (addr_hit && b_we_req) begin
            a_rd_next = b_data;
         end
         if (addr_hit && a_we) begin
            b_rd_next = a_data;
         end
      end
   end

   // Array writes; port B first so a same-word port A write overrides it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (b_we) begin
            mem[b_pa] <= b_data;
         end
         if (a_we) begin
            mem[a_pa] <= a_data;
         end
      end
   end

   // First read stage: capture words, valid strobes and the collision flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q1 <= '0;
         b_q1 <= '0;
         a_v1 <= 1'b0;
         b_v1 <= 1'b0;
         col1 <= 1'b0;
      end else begin
         a_v1 <= a_rd;
         b_v1 <= b_rd;
         col1 <= coll;
         if (a_rd) begin
            a_q1 <= a_rd_next;
         end
         if (b_rd) begin
            b_q1 <= b_rd_next;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] a_q2;
         logic [DATA_W-1:0] b_q2;
         logic              a_v2;
         logic              b_v2;
         logic              col2;

         // Optional output stage; it only reloads when fresh data arrives.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q2 <= '0;
               b_q2 <= '0;
               a_v2 <= 1'b0;
               b_v2 <= 1'b0;
               col2 <= 1'b0;
            end else begin
               a_v2 <= a_v1;
               b_v2 <= b_v1;
               col2 <= col1;
               if (a_v1) begin
                  a_q2 <= a_q1;
               end
               if (b_v1) begin
                  b_q2 <= b_q1;
               end
            end
         end

         assign a_q       = a_q2;
         assign b_q       = b_q2;
         assign a_valid   = a_v2;
         assign b_valid   = b_v2;
         assign collision = col2;
      end else begin : g_no_out_reg
         assign a_q       = a_q1;
         assign b_q       = b_q1;
         assign a_valid   = a_v1;
         assign b_valid   = b_v1;
         assign collision = col1;
      end
   endgenerate

   // Swap handshake; bank_sel and swap_ack change on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bank_sel <= 1'b0;
         swap_ack <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (swap_req) begin
                  if (ports_idle) begin
                     bank_sel <= ~bank_sel;
                     swap_ack <= 1'b1;
                  end else begin
                     state <= PEND;
                  end
               end
            end
            PEND: begin
               if (!swap_req) begin
                  state <= IDLE;
               end else if (ports_idle) begin
                  bank_sel <= ~bank_sel;
                  swap_ack <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Bench for fft_pingpong_ram: two instances share all inputs, one read-first
// without an output register and one write-first with the output register.
module tb_fft_pingpong_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_en, a_wr, a_alt, a_bitrev;
   logic [4:0]  a_addr;
   logic [15:0] a_data;
   logic        b_en, b_wr, b_alt;
   logic [4:0]  b_addr;
   logic [15:0] b_data;
   logic        swap_req;

   logic [15:0] a_q0, b_q0, a_q1, b_q1;
   logic        a_valid0, b_valid0, swap_ack0, bank_sel0, collision0;
   logic        a_valid1, b_valid1, swap_ack1, bank_sel1, collision1;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [15:0] mem_m [0:63];
   logic        bank_m;
   logic        e_ack;
   logic [15:0] e0_aq, e0_bq;
   logic        e0_av, e0_bv, e0_col;
   logic [15:0] s_aq, s_bq, e1_aq, e1_bq;
   logic        s_av, s_bv, s_col, e1_av, e1_bv, e1_col;

   always #5 clk = ~clk;

   fft_pingpong_ram #(.DATA_W(16), .ADDR_W(5), .RDW_MODE(0), .OUT_REG(0)) dut0 (
      .clk(clk), .rst(rst),
      .a_en(a_en), .a_wr(a_wr), .a_alt(a_alt), .a_bitrev(a_bitrev),
      .a_addr(a_addr), .a_data(a_data), .a_q(a_q0), .a_valid(a_valid0),
      .b_en(b_en), .b_wr(b_wr), .b_alt(b_alt),
      .b_addr(b_addr), .b_data(b_data), .b_q(b_q0), .b_valid(b_valid0),
      .swap_req(swap_req), .swap_ack(swap_ack0), .bank_sel(bank_sel0),
      .collision(collision0)
   );

   fft_pingpong_ram #(.DATA_W(16), .ADDR_W(5), .RDW_MODE(1), .OUT_REG(1)) dut1 (
      .clk(clk), .rst(rst),
      .a_en(a_en), .a_wr(a_wr), .a_alt(a_alt), .a_bitrev(a_bitrev),
      .a_addr(a_addr), .a_data(a_data), .a_q(a_q1), .a_valid(a_valid1),
      .b_en(b_en), .b_wr(b_wr), .b_alt(b_alt),
      .b_addr(b_addr), .b_data(b_data), .b_q(b_q1), .b_valid(b_valid1),
      .swap_req(swap_req), .swap_ack(swap_ack1), .bank_sel(bank_sel1),
      .collision(collision1)
   );

   task automatic idle_inputs();
      a_en = 0; a_wr = 0; a_alt = 0; a_bitrev = 0; a_addr = 0; a_data = 0;
      b_en = 0; b_wr = 0; b_alt = 0; b_addr = 0; b_data = 0;
      swap_req = 0;
   endtask

   // One clock with the current inputs; the model predicts what both
   // instances show after the edge.
   task automatic step();
      logic [4:0]  ea;
      logic [5:0]  pa, pb;
      logic        ar, br, col, idle;
      logic [15:0] ra_old, ra_new, rb_old, rb_new;
      for (int i = 0; i < 5; i++) ea[i] = a_bitrev ? a_addr[4-i] : a_addr[i];
      pa     = {bank_m ^ a_alt, ea};
      pb     = {bank_m ^ b_alt, b_addr};
      ar     = a_en && !a_wr;
      br     = b_en && !b_wr;
      col    = a_en && b_en && (pa == pb) && (a_wr || b_wr);
      idle   = !a_en && !b_en;
      ra_old = mem_m[pa];
      rb_old = mem_m[pb];
      ra_new = (col && b_wr) ? b_data : ra_old;
      rb_new = (col && a_wr) ? a_data : rb_old;
      @(posedge clk);
      #1;
      if (rst) begin
         bank_m = 0; e_ack = 0;
         e0_aq = 0; e0_bq = 0; e0_av = 0; e0_bv = 0; e0_col = 0;
         s_aq = 0; s_bq = 0; s_av = 0; s_bv = 0; s_col = 0;
         e1_aq = 0; e1_bq = 0; e1_av = 0; e1_bv = 0; e1_col = 0;
      end else begin
         e1_av = s_av; if (s_av) e1_aq = s_aq;
         e1_bv = s_bv; if (s_bv) e1_bq = s_bq;
         e1_col = s_col;
         s_av = ar; if (ar) s_aq = ra_new;
         s_bv = br; if (br) s_bq = rb_new;
         s_col = col;
         e0_av = ar; if (ar) e0_aq = ra_old;
         e0_bv = br; if (br) e0_bq = rb_old;
         e0_col = col;
         if (b_en && b_wr && !(col && a_wr)) mem_m[pb] = b_data;
         if (a_en && a_wr) mem_m[pa] = a_data;
         e_ack = 0;
         if (swap_req && idle) begin
            bank_m = ~bank_m;
            e_ack  = 1;
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      step();
      step();
      n_vec++;
      if ({a_q0, b_q0, a_valid0, b_valid0, collision0, swap_ack0, bank_sel0} !== 37'd0) begin
         n_err++;
         $display("FAIL reset_dut0: got %h %h %b%b%b%b%b required all zero",
                  a_q0, b_q0, a_valid0, b_valid0, collision0, swap_ack0, bank_sel0);
      end
      n_vec++;
      if ({a_q1, b_q1, a_valid1, b_valid1, collision1, swap_ack1, bank_sel1} !== 37'd0) begin
         n_err++;
         $display("FAIL reset_dut1: got %h %h %b%b%b%b%b required all zero",
                  a_q1, b_q1, a_valid1, b_valid1, collision1, swap_ack1, bank_sel1);
      end
      rst = 0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 64; i++) begin
         a_en = 1; a_wr = 1; a_alt = i[5]; a_addr = i[4:0];
         a_data = 16'($urandom);
         step();
      end
      idle_inputs();
      step();
      n_vec++;
      if (a_valid0 !== 1'b0 || a_valid1 !== 1'b0) begin
         n_err++;
         $display("FAIL fill_no_valid: got %b %b required 0 0", a_valid0, a_valid1);
      end
   endtask

   task automatic test_basic();
      a_en = 1; a_wr = 1; a_addr = 3; a_data = 16'h1234;
      step();
      n_vec++;
      if (b_valid0 !== 1'b0) begin
         n_err++; $display("FAIL basic_wr_valid: got %b required 0", b_valid0);
      end
      a_en = 0; b_en = 1; b_wr = 0; b_addr = 3;
      step();
      n_vec++;
      if (b_q0 !== 16'h1234 || b_valid0 !== 1'b1 || b_valid1 !== 1'b0) begin
         n_err++;
         $display("FAIL basic_rd_lat1: got q=%h v=%b v1=%b required 1234 1 0", b_q0, b_valid0, b_valid1);
      end
      b_en = 0;
      step();
      n_vec++;
      if (b_q0 !== 16'h1234 || b_valid0 !== 1'b0 || b_q1 !== 16'h1234 || b_valid1 !== 1'b1) begin
         n_err++;
         $display("FAIL basic_rd_lat2: got q0=%h v0=%b q1=%h v1=%b required 1234 0 1234 1",
                  b_q0, b_valid0, b_q1, b_valid1);
      end
   endtask

   task automatic test_bitrev();
      a_en = 1; a_wr = 1; a_bitrev = 1; a_addr = 5'b00001; a_data = 16'hBEEF;
      step();
      a_en = 0; a_bitrev = 0;
      b_en = 1; b_wr = 0; b_addr = 16;
      step();
      n_vec++;
      if (b_q0 !== 16'hBEEF || b_valid0 !== 1'b1) begin
         n_err++; $display("FAIL bitrev_dut0: got %h v=%b required beef 1", b_q0, b_valid0);
      end
      b_en = 0;
      step();
      n_vec++;
      if (b_q1 !== 16'hBEEF || b_valid1 !== 1'b1) begin
         n_err++; $display("FAIL bitrev_dut1: got %h v=%b required beef 1", b_q1, b_valid1);
      end
   endtask

   task automatic test_ww_collision();
      a_en = 1; a_wr = 1; a_addr = 7; a_data = 16'h1111;
      b_en = 1; b_wr = 1; b_addr = 7; b_data = 16'h2222;
      step();
      n_vec++;
      if (collision0 !== 1'b1 || collision1 !== 1'b0) begin
         n_err++; $display("FAIL ww_col_pulse: got %b %b required 1 0", collision0, collision1);
      end
      a_en = 0; b_wr = 0;
      step();
      n_vec++;
      if (collision0 !== 1'b0 || collision1 !== 1'b1 || b_q0 !== 16'h1111) begin
         n_err++;
         $display("FAIL ww_col_data: got col=%b %b q=%h required 0 1 1111", collision0, collision1, b_q0);
      end
      b_en = 0;
      step();
      n_vec++;
      if (b_q1 !== 16'h1111 || collision1 !== 1'b0) begin
         n_err++; $display("FAIL ww_col_dut1: got q=%h col=%b required 1111 0", b_q1, collision1);
      end
   endtask

   task automatic test_wr_collision();
      a_en = 1; a_wr = 1; a_addr = 9; a_data = 16'hAAAA;
      step();
      a_data = 16'h5555;
      b_en = 1; b_wr = 0; b_addr = 9;
      step();
      n_vec++;
      if (b_q0 !== 16'hAAAA || collision0 !== 1'b1 || b_valid0 !== 1'b1) begin
         n_err++;
         $display("FAIL wr_col_readfirst: got q=%h col=%b v=%b required aaaa 1 1", b_q0, collision0, b_valid0);
      end
      a_en = 0; b_en = 0;
      step();
      n_vec++;
      if (b_q1 !== 16'h5555 || collision1 !== 1'b1 || b_valid1 !== 1'b1) begin
         n_err++;
         $display("FAIL wr_col_writefirst: got q=%h col=%b v=%b required 5555 1 1", b_q1, collision1, b_valid1);
      end
   endtask

   task automatic test_swap_idle();
      a_en = 1; a_wr = 1; a_alt = 0; a_addr = 0; a_data = 16'h0F0F;
      step();
      a_alt = 1; a_data = 16'hF0F0;
      step();
      idle_inputs();
      swap_req = 1;
      step();
      n_vec++;
      if (swap_ack0 !== 1'b1 || bank_sel0 !== 1'b1 || swap_ack1 !== 1'b1 || bank_sel1 !== 1'b1) begin
         n_err++;
         $display("FAIL swap_idle_ack: got ack=%b%b bank=%b%b required 11 11",
                  swap_ack0, swap_ack1, bank_sel0, bank_sel1);
      end
      swap_req = 0;
      b_en = 1; b_wr = 0; b_alt = 0; b_addr = 0;
      step();
      n_vec++;
      if (swap_ack0 !== 1'b0 || b_q0 !== 16'hF0F0 || bank_sel0 !== 1'b1) begin
         n_err++;
         $display("FAIL swap_idle_read: got ack=%b q=%h bank=%b required 0 f0f0 1", swap_ack0, b_q0, bank_sel0);
      end
      b_en = 0;
      step();
      n_vec++;
      if (b_q1 !== 16'hF0F0) begin
         n_err++; $display("FAIL swap_idle_read1: got %h required f0f0", b_q1);
      end
   endtask

   task automatic test_swap_pend();
      swap_req = 1;
      b_en = 1; b_wr = 0;
      for (int k = 0; k < 4; k++) begin
         b_addr = 5'(k);
         step();
         n_vec++;
         if (swap_ack0 !== 1'b0 || bank_sel0 !== 1'b1 || swap_ack1 !== 1'b0) begin
            n_err++;
            $display("FAIL swap_pend_wait%0d: got ack=%b%b bank=%b required 00 1", k, swap_ack0, swap_ack1, bank_sel0);
         end
      end
      b_en = 0;
      step();
      n_vec++;
      if (swap_ack0 !== 1'b1 || bank_sel0 !== 1'b0 || swap_ack1 !== 1'b1 || bank_sel1 !== 1'b0) begin
         n_err++;
         $display("FAIL swap_pend_done: got ack=%b%b bank=%b%b required 11 00",
                  swap_ack0, swap_ack1, bank_sel0, bank_sel1);
      end
      swap_req = 0;
      step();
      n_vec++;
      if (swap_ack0 !== 1'b0 || bank_sel0 !== 1'b0) begin
         n_err++; $display("FAIL swap_pend_after: got ack=%b bank=%b required 0 0", swap_ack0, bank_sel0);
      end
      // get bank_sel to 1 so the reset below visibly clears it
      swap_req = 1;
      step();
      swap_req = 0;
      step();
      swap_req = 1; b_en = 1; b_addr = 5;
      step();
      step();
      rst = 1; b_en = 0;
      step();
      n_vec++;
      if (bank_sel0 !== 1'b0 || swap_ack0 !== 1'b0 || b_valid0 !== 1'b0 || b_q0 !== 16'h0 ||
          bank_sel1 !== 1'b0 || b_valid1 !== 1'b0 || b_q1 !== 16'h0 || swap_ack1 !== 1'b0) begin
         n_err++;
         $display("FAIL rst_in_pend: got bank=%b%b ack=%b%b v=%b%b q=%h %h required all zero",
                  bank_sel0, bank_sel1, swap_ack0, swap_ack1, b_valid0, b_valid1, b_q0, b_q1);
      end
      rst = 0; swap_req = 0;
      step();
      n_vec++;
      if (swap_ack0 !== 1'b0 || bank_sel0 !== 1'b0 || b_valid1 !== 1'b0 || collision1 !== 1'b0) begin
         n_err++;
         $display("FAIL rst_flush: got ack=%b bank=%b v1=%b col1=%b required 0 0 0 0",
                  swap_ack0, bank_sel0, b_valid1, collision1);
      end
   endtask

   task automatic test_random();
      logic [36:0] got, exp;
      for (int n = 0; n < 600; n++) begin
         logic [4:0] mask;
         mask     = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'h11;
         rst      = ($urandom_range(0, 79) == 0);
         a_en     = 1'($urandom); a_wr = 1'($urandom); a_alt = 1'($urandom);
         a_bitrev = 1'($urandom); a_addr = 5'($urandom) & mask; a_data = 16'($urandom);
         b_en     = 1'($urandom); b_wr = 1'($urandom); b_alt = 1'($urandom);
         b_addr   = 5'($urandom) & mask; b_data = 16'($urandom);
         swap_req = ($urandom_range(0, 3) == 0);
         step();
         got = {a_q0, a_valid0, b_q0, b_valid0, collision0, swap_ack0, bank_sel0};
         exp = {e0_aq, e0_av, e0_bq, e0_bv, e0_col, e_ack, bank_m};
         n_vec++;
         if (got !== exp) begin
            n_err++; $display("FAIL random_dut0 cycle %0d: got %h required %h", n, got, exp);
         end
         got = {a_q1, a_valid1, b_q1, b_valid1, collision1, swap_ack1, bank_sel1};
         exp = {e1_aq, e1_av, e1_bq, e1_bv, e1_col, e_ack, bank_m};
         n_vec++;
         if (got !== exp) begin
            n_err++; $display("FAIL random_dut1 cycle %0d: got %h required %h", n, got, exp);
         end
      end
      rst = 0;
      idle_inputs();
      step();
   endtask

   initial begin
      bank_m = 0;
      idle_inputs();
      rst = 1;
      test_reset();
      test_fill();
      test_basic();
      test_bitrev();
      test_ww_collision();
      test_wr_collision();
      test_swap_idle();
      test_swap_pend();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
